// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from execute
// and the {instr, pc} handshake towards decode.
interface instr_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order word fetches with credit-limited outstanding count, pairs
// responses with their PC and presents them to decode (>= 2 cycles request to output).
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ent_pc_q    [DEPTH];
   logic [31:0]      ent_instr_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [AW-1:0]    head_q, tail_q, wr_q;
   logic [CW-1:0]    count_q, pend_q, discard_q;
   logic [CW-1:0]    count_d, pend_d, discard_d;

   logic credit_ok, req_fire, rsp_drop, rsp_fill, out_vld, pop;

   // Credits cover both live entries and responses still owed to a flushed stream.
   assign credit_ok          = (int'(count_q) + int'(discard_q)) < DEPTH;
   assign bus.imem_req_valid = rst_n && !bus.redirect_valid && credit_ok;
   assign bus.imem_req_addr  = pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_drop           = bus.imem_rsp_valid && (discard_q != '0);
   assign rsp_fill           = bus.imem_rsp_valid && (discard_q == '0);
   assign out_vld            = filled_q[head_q] && !bus.redirect_valid;
   assign bus.out_valid      = out_vld;
   assign bus.out_instr      = ent_instr_q[head_q];
   assign bus.out_pc         = ent_pc_q[head_q];
   assign pop                = out_vld && bus.out_ready;

   always_comb begin
      pc_d      = pc_q;
      count_d   = count_q;
      pend_d    = pend_q;
      discard_d = discard_q;
      if (bus.redirect_valid) begin
         pc_d      = bus.redirect_pc & 32'hFFFF_FFFC;
         count_d   = '0;
         pend_d    = '0;
         // Every unfilled entry still owes a response; one arriving now is already paid.
         discard_d = discard_q + pend_q - CW'(bus.imem_rsp_valid);
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         count_d   = count_q + CW'(req_fire) - CW'(pop);
         pend_d    = pend_q + CW'(req_fire) - CW'(rsp_fill);
         discard_d = discard_q - CW'(rsp_drop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         head_q    <= '0;
         tail_q    <= '0;
         wr_q      <= '0;
         filled_q  <= '0;
         count_q   <= '0;
         pend_q    <= '0;
         discard_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc_q[i]    <= '0;
            ent_instr_q[i] <= '0;
         end
      end else begin
         pc_q      <= pc_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         discard_q <= discard_d;
         if (bus.redirect_valid) begin
            head_q   <= '0;
            tail_q   <= '0;
            wr_q     <= '0;
            filled_q <= '0;
         end else begin
            if (req_fire) begin
               ent_pc_q[tail_q] <= pc_q;
               tail_q           <= tail_q + AW'(1);
            end
            if (rsp_fill) begin
               ent_instr_q[wr_q] <= bus.imem_rsp_data;
               filled_q[wr_q]    <= 1'b1;
               wr_q              <= wr_q + AW'(1);
            end
            if (pop) begin
               filled_q[head_q] <= 1'b0;
               head_q           <= head_q + AW'(1);
            end
         end
      end
   end

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      bus.imem_rsp_valid |-> (pend_q != '0 || discard_q != '0));
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench: in-order memory model with 1-5 cycle latency, program-order
// reference stream of {pc, instr}, and a separate output monitor/scoreboard.
module tb_instr_fetch;
   localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
   localparam int          DEPTH    = 2;

   typedef struct { int due; logic [31:0] data; } rsp_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   int          fires = 0;
   int          out_cnt = 0;
   int          last_due = -1;
   logic [31:0] m_pc = RESET_PC;
   rsp_t        mem_q[$];
   exp_t        exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   // One clock of stimulus; the model advances on every accepted request or redirect.
   task automatic cycle(input bit rdy, input int lmin, input int lmax, input bit ordy,
                        input bit redir, input logic [31:0] rpc);
      bit presented;
      int due;
      @(negedge clk);
      bus.imem_req_ready = rdy;
      bus.out_ready      = ordy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      presented = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      if (presented) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_q[0].data;
         void'(mem_q.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
      #1;
      if (redir) begin
         chk("req_valid_in_redirect", {31'b0, bus.imem_req_valid}, 32'd0);
         exp_q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else if (bus.imem_req_valid && rdy) begin
         chk("req_addr", bus.imem_req_addr, m_pc);
         exp_q.push_back('{m_pc, mem_word(m_pc)});
         due = cyc + int'($urandom_range(lmax, lmin));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{due, mem_word(bus.imem_req_addr)});
         chk("in_flight_le_depth", {31'b0, (mem_q.size() + int'(presented)) <= DEPTH}, 32'd1);
         m_pc  = m_pc + 32'd4;
         fires++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b0;
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      mem_q.delete();
      exp_q.delete();
      m_pc     = RESET_PC;
      last_due = -1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops the reference stream on each decode handshake and checks stalls hold.
   initial begin
      bit          hold_pend = 0;
      logic [31:0] hold_pc = '0;
      logic [31:0] hold_instr = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            hold_pend = 0;
         end else begin
            if (hold_pend && !bus.redirect_valid) begin
               chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
               chk("hold_pc", bus.out_pc, hold_pc);
               chk("hold_instr", bus.out_instr, hold_instr);
            end
            hold_pend = 0;
            if (bus.out_valid && bus.out_ready) begin
               out_cnt++;
               chk("out_expected", {31'b0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("out_pc", bus.out_pc, e.pc);
                  chk("out_instr", bus.out_instr, e.instr);
               end
            end else if (bus.out_valid) begin
               hold_pend  = 1;
               hold_pc    = bus.out_pc;
               hold_instr = bus.out_instr;
            end
         end
      end
   end

   initial begin
      int base;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.out_ready      = 1'b0;

      // Streaming from a reset PC that wraps through 0.
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 1, 0, 0);
      base = out_cnt;
      for (int i = 0; i < 30; i++) cycle(1, 1, 1, 1, 0, 0);
      chk("steady_throughput", {31'b0, (out_cnt - base) >= 18}, 32'd1);

      // Decode stalled: credits cap requests at DEPTH, head output holds.
      do_reset();
      base = fires;
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 0, 0);
      chk("stall_req_count", fires - base, DEPTH);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1, 0, 0);
      chk("stall_drained", exp_q.size(), 32'd0);

      // Redirect with two fetches in flight, then back-to-back redirects.
      cycle(1, 5, 5, 1, 0, 0);
      cycle(1, 5, 5, 1, 0, 0);
      cycle(1, 1, 1, 1, 1, 32'h0000_0103);
      for (int i = 0; i < 12; i++) cycle(1, 1, 3, 1, 0, 0);
      cycle(1, 2, 4, 1, 0, 0);
      cycle(1, 1, 1, 1, 1, 32'h0000_0200);
      cycle(1, 1, 1, 1, 1, 32'h0000_0302);
      for (int i = 0; i < 15; i++) cycle(1, 1, 5, 1, 0, 0);
      for (int i = 0; i < 15; i++) cycle(0, 1, 1, 1, 0, 0);
      chk("redirect_drained", exp_q.size(), 32'd0);

      // Reset mid-stream with fetches outstanding and decode stalled.
      cycle(1, 2, 2, 0, 0, 0);
      cycle(1, 5, 5, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 1, 2, 1, 0, 0);

      // Random traffic with occasional redirects and resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999) do_reset();
         else cycle(($urandom % 4) != 0, 1, 5, ($urandom % 3) != 0,
                    ($urandom % 40) == 0, $urandom);
      end
      for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1, 0, 0);
      chk("final_drained", exp_q.size(), 32'd0);
      chk("outputs_seen", {31'b0, out_cnt > 500}, 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
